cosim_result_misr: RTL and testbench

COSIM_RESULT_MISR -- requirements
Module: cosim_result_misr

---
 rtl/cosim_pkg.sv | 27 ++
 rtl/misr128.sv | 12 +
 rtl/cosim_result_misr.sv | 133 +++++++++++++
 tb/tb_cosim_result_misr.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_pkg.sv
// Shared types, constants and the MISR step function for the result compactor.
package cosim_pkg;

   // Capture-run controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Feedback taps of the 128-bit MISR (x^128 + x^7 + x^2 + x + 1).
   localparam logic [127:0] MISR_POLY = 128'h87;

   // One MISR clock: shift left, reduce by the polynomial when the MSB falls out,
   // then absorb the masked result vector.
   function automatic logic [127:0] misr_step(input logic [127:0] sig_in,
                                              input logic [127:0] term);
      logic [127:0] t;
      t = {sig_in[126:0], 1'b0};
      if (sig_in[127]) begin
         t = t ^ MISR_POLY;
      end
      return t ^ term;
   endfunction

endpackage

// File: rtl/misr128.sv
// Combinational single-step MISR fold used by the capture controller.
module misr128
   import cosim_pkg::*;
(
   input  logic [127:0] sig_i,
   input  logic [127:0] term_i,
   output logic [127:0] sig_o
);

   assign sig_o = misr_step(sig_i, term_i);

endmodule

// File: rtl/cosim_result_misr.sv
// Compacts a run of 128-bit DUT result vectors into a MISR signature,
// excluding X/Z bits and counting vectors that carried any X.
//
// Handshake: a vector transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is high for every cycle in RUN: the stage register
// always drains into the signature on the cycle after it is loaded, so a new
// vector can be taken while the previous one folds (one vector per cycle).
// The producer must hold in_data/in_xmask stable while in_valid is high and
// in_ready is low; nothing is captured in that case.
module cosim_result_misr
   import cosim_pkg::*;
#(
   parameter logic [127:0] SEED  = 128'h0,
   parameter int           CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vecs,
   input  logic             in_valid,
   input  logic [127:0]     in_data,
   input  logic [127:0]     in_xmask,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [127:0]     sig,
   output logic [CNT_W-1:0] vec_count,
   output logic [7:0]       x_vecs,
   output state_t           dbg_state
);

   state_t             state_q;
   logic [127:0]       sig_q;
   logic [127:0]       sig_d;
   logic [CNT_W-1:0]   vec_count_q;
   logic [7:0]         x_vecs_q;
   logic [CNT_W-1:0]   remaining_q;
   logic               stage_vld_q;
   logic [127:0]       stage_term_q;
   logic               stage_anyx_q;
   logic               in_ready_q;
   logic               busy_q;
   logic               done_q;
   logic               accept;

   assign accept = in_valid & in_ready_q;

   misr128 u_misr (
      .sig_i  (sig_q),
      .term_i (stage_term_q),
      .sig_o  (sig_d)
   );

   // Run controller, stage register and signature/counter state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sig_q        <= SEED;
         vec_count_q  <= '0;
         x_vecs_q     <= '0;
         remaining_q  <= '0;
         stage_vld_q  <= 1'b0;
         stage_term_q <= '0;
         stage_anyx_q <= 1'b0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // Fold the staged vector; the stage is only ever full in RUN/FOLD.
         if (stage_vld_q) begin
            sig_q       <= sig_d;
            vec_count_q <= vec_count_q + 1'b1;
            if (stage_anyx_q && (x_vecs_q != 8'hFF)) begin
               x_vecs_q <= x_vecs_q + 8'd1;
            end
         end

         stage_vld_q <= accept;
         if (accept) begin
            stage_term_q <= in_data & ~in_xmask;
            stage_anyx_q <= |in_xmask;
            remaining_q  <= remaining_q - 1'b1;
         end

         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  sig_q       <= SEED;
                  vec_count_q <= '0;
                  x_vecs_q    <= '0;
                  remaining_q <= num_vecs;
                  if (num_vecs == '0) begin
                     state_q    <= ST_DONE;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     state_q    <= ST_RUN;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                     done_q     <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (accept && (remaining_q == CNT_W'(1))) begin
                  state_q    <= ST_FOLD;
                  in_ready_q <= 1'b0;
               end
            end
            ST_FOLD: begin
               if (stage_vld_q) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sig       = sig_q;
   assign vec_count = vec_count_q;
   assign x_vecs    = x_vecs_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cosim_result_misr.sv
// Directed testbench for cosim_result_misr: one task per scenario, inline checks.
module tb_cosim_result_misr;
   import cosim_pkg::*;

   localparam int CNT_W = 16;
   localparam logic [127:0] MSB_SEED = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT with SEED = 0 ----------------
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_vecs = '0;
   logic             in_valid = 1'b0;
   logic [127:0]     in_data = '0;
   logic [127:0]     in_xmask = '0;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic [127:0]     sig;
   logic [CNT_W-1:0] vec_count;
   logic [7:0]       x_vecs;
   state_t           dbg_state;

   cosim_result_misr #(.SEED(128'h0), .CNT_W(CNT_W)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .num_vecs  (num_vecs),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_xmask  (in_xmask),
      .in_ready  (in_ready),
      .busy      (busy),
      .done      (done),
      .sig       (sig),
      .vec_count (vec_count),
      .x_vecs    (x_vecs),
      .dbg_state (dbg_state)
   );

   // ---------------- DUT with MSB seed ----------------
   logic             start1 = 1'b0;
   logic [CNT_W-1:0] num1 = '0;
   logic             valid1 = 1'b0;
   logic [127:0]     data1 = '0;
   logic [127:0]     mask1 = '0;
   logic             ready1;
   logic             busy1;
   logic             done1;
   logic [127:0]     sig1;
   logic [CNT_W-1:0] cnt1;
   logic [7:0]       xv1;
   state_t           state1;

   cosim_result_misr #(.SEED(MSB_SEED), .CNT_W(CNT_W)) u_dut_msb (
      .clk       (clk),
      .reset     (reset),
      .start     (start1),
      .num_vecs  (num1),
      .in_valid  (valid1),
      .in_data   (data1),
      .in_xmask  (mask1),
      .in_ready  (ready1),
      .busy      (busy1),
      .done      (done1),
      .sig       (sig1),
      .vec_count (cnt1),
      .x_vecs    (xv1),
      .dbg_state (state1)
   );

   int total = 0;
   int bad   = 0;

   // Reference MISR written bit by bit from the polynomial definition.
   function automatic logic [127:0] ref_step(input logic [127:0] s, input logic [127:0] m);
      logic [127:0] r;
      logic [127:0] poly;
      poly = 128'h87;
      for (int i = 0; i < 128; i++) begin
         r[i] = ((i == 0) ? 1'b0 : s[i-1]) ^ (s[127] & poly[i]) ^ m[i];
      end
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   // All stimulus changes and all sampling happen on the falling edge.
   task automatic do_start(input logic [CNT_W-1:0] n);
      start    = 1'b1;
      num_vecs = n;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic send_vec(input logic [127:0] d, input logic [127:0] m);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_xmask = m;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL wait_done: done=%0b required=1 after %0d cycles", done, n);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got=%0d exp=%0d", dbg_state, ST_IDLE); end
      total++; if (sig !== 128'h0) begin bad++; $display("FAIL rst_sig: got=%h exp=0", sig); end
      total++; if (vec_count !== '0 || x_vecs !== 8'd0) begin bad++; $display("FAIL rst_cnt: vc=%0d xv=%0d exp=0/0", vec_count, x_vecs); end
      total++; if ({in_ready, busy, done} !== 3'b000) begin bad++; $display("FAIL rst_flags: rdy/busy/done=%b exp=000", {in_ready, busy, done}); end
      total++; if (sig1 !== MSB_SEED) begin bad++; $display("FAIL rst_sig_msb: got=%h exp=%h", sig1, MSB_SEED); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      do_start(16'd1);
      total++; if (dbg_state !== ST_RUN || in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_run: st=%0d rdy=%0b busy=%0b exp=1/1/1", dbg_state, in_ready, busy); end
      in_valid = 1'b1; in_data = 128'h1; in_xmask = '0;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (dbg_state !== ST_FOLD || in_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL single_fold: st=%0d rdy=%0b done=%0b exp=2/0/0", dbg_state, in_ready, done); end
      @(negedge clk);
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL single_done: done=%0b busy=%0b exp=1/0", done, busy); end
      total++; if (sig !== 128'h1 || vec_count !== 16'd1) begin bad++; $display("FAIL single_sig: sig=%h vc=%0d exp=1/1", sig, vec_count); end
      // DONE holds the signature even with in_valid asserted.
      in_valid = 1'b1; in_data = 128'hFFFF;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      total++; if (sig !== 128'h1 || vec_count !== 16'd1 || in_ready !== 1'b0) begin bad++; $display("FAIL done_hold: sig=%h vc=%0d rdy=%0b exp=1/1/0", sig, vec_count, in_ready); end
   endtask

   task automatic test_back_to_back();
      do_start(16'd2);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy0: got=%0b exp=1", in_ready); end
      in_valid = 1'b1; in_data = 128'h1; in_xmask = '0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy1: got=%0b exp=1", in_ready); end
      in_data = 128'h0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (done !== 1'b1 || sig !== 128'h2 || vec_count !== 16'd2) begin bad++; $display("FAIL b2b_sig: done=%0b sig=%h vc=%0d exp=1/2/2", done, sig, vec_count); end
   endtask

   task automatic test_zero();
      int rdy_seen;
      rdy_seen = 0;
      do_start(16'd0);
      total++; if (dbg_state !== ST_DONE || done !== 1'b1) begin bad++; $display("FAIL zero_done: st=%0d done=%0b exp=3/1", dbg_state, done); end
      total++; if (sig !== 128'h0 || vec_count !== '0) begin bad++; $display("FAIL zero_sig: sig=%h vc=%0d exp=0/0", sig, vec_count); end
      in_valid = 1'b1; in_data = 128'h5;
      for (int i = 0; i < 3; i++) begin
         if (in_ready) rdy_seen++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (rdy_seen != 0 || vec_count !== '0 || sig !== 128'h0) begin bad++; $display("FAIL zero_noaccept: rdy_cycles=%0d vc=%0d sig=%h exp=0/0/0", rdy_seen, vec_count, sig); end
   endtask

   task automatic test_start_ignored();
      do_start(16'd2);
      send_vec(128'h5, '0);
      do_start(16'd9);
      total++; if (dbg_state !== ST_RUN || vec_count !== 16'd1) begin bad++; $display("FAIL ign_state: st=%0d vc=%0d exp=1/1", dbg_state, vec_count); end
      send_vec(128'h3, '0);
      wait_done(10);
      // (5<<1)^3 = 9
      total++; if (sig !== 128'h9 || vec_count !== 16'd2) begin bad++; $display("FAIL ign_sig: sig=%h vc=%0d exp=9/2", sig, vec_count); end
   endtask

   task automatic test_xmask();
      logic [127:0] ones;
      logic [127:0] exp_sig;
      ones = '1;
      do_start(16'd1);
      send_vec(ones, 128'hFF);
      wait_done(10);
      total++; if (sig !== ~128'hFF || x_vecs !== 8'd1) begin bad++; $display("FAIL xmask_one: sig=%h xv=%0d exp=%h/1", sig, x_vecs, ~128'hFF); end
      exp_sig = '0;
      do_start(16'd300);
      for (int i = 0; i < 300; i++) begin
         send_vec(ones, 128'hFF);
         exp_sig = ref_step(exp_sig, ~128'hFF);
      end
      wait_done(10);
      total++; if (x_vecs !== 8'd255 || vec_count !== 16'd300) begin bad++; $display("FAIL xmask_sat: xv=%0d vc=%0d exp=255/300", x_vecs, vec_count); end
      total++; if (sig !== exp_sig) begin bad++; $display("FAIL xmask_sig: sig=%h exp=%h", sig, exp_sig); end
   endtask

   task automatic test_reset_midrun();
      logic [127:0] d [4];
      logic [127:0] m [4];
      logic [127:0] exp_sig;
      do_start(16'd5);
      send_vec(128'h1, '0);
      send_vec(128'h2, '0);
      send_vec(128'h3, '0);
      reset = 1'b1;
      @(negedge clk);
      total++; if (dbg_state !== ST_IDLE || sig !== 128'h0 || vec_count !== '0) begin bad++; $display("FAIL mid_rst: st=%0d sig=%h vc=%0d exp=0/0/0", dbg_state, sig, vec_count); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (sig !== 128'h0 || vec_count !== '0 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_residual: sig=%h vc=%0d rdy=%0b exp=0/0/0", sig, vec_count, in_ready); end
      d[0] = 128'hA5A5_A5A5_0000_1111_2222_3333_4444_5555; m[0] = '0;
      d[1] = 128'hFFFF;                                 m[1] = 128'hF0;
      d[2] = MSB_SEED;                                  m[2] = '0;
      d[3] = 128'h1234_5678_9ABC_DEF0;                  m[3] = '0;
      exp_sig = '0;
      do_start(16'd4);
      for (int i = 0; i < 4; i++) begin
         send_vec(d[i], m[i]);
         exp_sig = ref_step(exp_sig, d[i] & ~m[i]);
      end
      wait_done(10);
      total++; if (sig !== exp_sig || vec_count !== 16'd4 || x_vecs !== 8'd1) begin bad++; $display("FAIL fresh_run: sig=%h vc=%0d xv=%0d exp=%h/4/1", sig, vec_count, x_vecs, exp_sig); end
   endtask

   task automatic test_seed_msb();
      start1 = 1'b1; num1 = 16'd1;
      @(negedge clk);
      start1 = 1'b0;
      total++; if (sig1 !== MSB_SEED || ready1 !== 1'b1) begin bad++; $display("FAIL msb_load: sig=%h rdy=%0b exp=%h/1", sig1, ready1, MSB_SEED); end
      valid1 = 1'b1; data1 = '0; mask1 = '0;
      @(negedge clk);
      valid1 = 1'b0;
      @(negedge clk);
      total++; if (done1 !== 1'b1 || sig1 !== 128'h87 || cnt1 !== 16'd1) begin bad++; $display("FAIL msb_sig: done=%0b sig=%h vc=%0d exp=1/87/1", done1, sig1, cnt1); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_zero();
      test_start_ignored();
      test_xmask();
      test_reset_midrun();
      test_seed_msb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
